// File: rtl/ssd_image_pkg.sv
// Shared types and elaboration helpers for the SSD image stream buffer.
package ssd_image_pkg;

    // Raster scanner states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } scan_state_e;

    // Number of pixels held in one frame.
    function automatic int unsigned calc_depth(input int unsigned img_width,
                                               input int unsigned img_height);
        return img_width * img_height;
    endfunction

    // True when a frame of 'depth' words is addressable with 'addr_width' bits.
    function automatic bit depth_fits(input int unsigned depth, input int unsigned addr_width);
        return 64'(depth) <= (64'd1 << addr_width);
    endfunction

    // Bits needed to index the RAM array (at least one).
    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ssd_skid_buffer.sv
// Two-entry valid/ready buffer. Entry 0 is always the head presented downstream,
// so the output payload only changes when it is consumed or the buffer is empty.
module ssd_skid_buffer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data0_q;
    assign count     = count_q;

    // Next-state for the two entries and the occupancy count.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        count_d = count_q;
        push    = in_valid & in_ready;
        pop     = out_valid & out_ready;
        if (flush) begin
            data0_d = '0;
            data1_d = '0;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        data0_d = in_data;
                    end else begin
                        data1_d = in_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    data0_d = data1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Push with pop is only possible with one entry held.
                    data0_d = in_data;
                end
                default: ;
            endcase
        end
    end

    // Entry and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data0_q <= '0;
            data1_q <= '0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ssd_image_stream_buffer.sv
// Frame memory with an Avalon-MM slave port for the Nios and a raster scanner
// that streams the whole frame onto an Avalon-ST source with sop/eop markers.
module ssd_image_stream_buffer
    import ssd_image_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned IMG_WIDTH         = 304,
    parameter int unsigned IMG_HEIGHT        = 192,
    parameter int unsigned ADDR_WIDTH        = 16,
    parameter bit          WRITE_NEEDS_DEBUG = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic                  debugaccess,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_sop,
    output logic                  src_eop
);

    localparam int unsigned           DEPTH   = calc_depth(IMG_WIDTH, IMG_HEIGHT);
    localparam int unsigned           IDX_W   = index_width(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    if (!depth_fits(DEPTH, ADDR_WIDTH)) begin : g_depth_check
        $error("IMG_WIDTH*IMG_HEIGHT does not fit in 2^ADDR_WIDTH words");
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // ---------------- Port A: Avalon-MM slave ----------------
    logic                  addr_ok;
    logic                  wr_en;
    logic                  rd_en;
    logic [IDX_W-1:0]      a_idx;
    logic [DATA_WIDTH-1:0] readdata_q;
    logic                  readdatavalid_q;

    assign addr_ok = ({1'b0, address} < DEPTH_W);
    assign a_idx   = address[IDX_W-1:0];
    assign wr_en   = chipselect & write & (debugaccess | ~WRITE_NEEDS_DEBUG) & addr_ok;
    // A write strobe in the same cycle suppresses the read entirely.
    assign rd_en   = chipselect & read & ~write;

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[a_idx] <= writedata;
        end
    end

    // Fixed-latency MM read; out-of-range addresses read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= rd_en;
            if (rd_en) begin
                readdata_q <= addr_ok ? mem[a_idx] : '0;
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

    // ---------------- Port B: raster scanner ----------------
    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  flush;
    logic                  pop;
    logic [2:0]            occ_next;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_sop_q;
    logic                  rd_eop_q;
    logic [1:0]            skid_count;
    logic                  skid_in_ready;
    logic [DATA_WIDTH+1:0] skid_out;

    assign pop      = src_valid & src_ready;
    // Skid occupancy after this cycle, counting the read whose data lands now.
    assign occ_next = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};

    // Scanner next-state, read issue and flush control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        issue_addr = cnt_q;
        flush      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    // Pixel 0 is read in the start cycle so the first beat
                    // appears two cycles later; the counter then points at 1.
                    issue      = 1'b1;
                    issue_addr = '0;
                    cnt_d      = ADDR_WIDTH'(1);
                    state_d    = (LAST == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (occ_next <= 3'd1) begin
                    issue = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (pop && src_eop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scanner state, pixel counter and in-flight read flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= issue;
        end
    end

    // Port-B RAM read; a same-cycle port-A write to this address yields old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
        end else if (issue) begin
            rd_data_q <= mem[issue_addr[IDX_W-1:0]];
            rd_sop_q  <= (issue_addr == '0);
            rd_eop_q  <= (issue_addr == LAST);
        end
    end

    ssd_skid_buffer #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_data  ({rd_data_q, rd_sop_q, rd_eop_q}),
        .in_valid (inflight_q & ~flush),
        .in_ready (skid_in_ready),
        .out_data (skid_out),
        .out_valid(src_valid),
        .out_ready(src_ready),
        .count    (skid_count)
    );

    assign src_data = skid_out[DATA_WIDTH+1:2];
    assign src_sop  = skid_out[1];
    assign src_eop  = skid_out[0];
    assign busy     = (state_q != StIdle);

    // Accounting guarantees room for every in-flight read.
    always_ff @(posedge clk) begin
        if (!reset && inflight_q && !flush) begin
            assert (skid_in_ready) else $error("skid buffer overflow");
        end
    end

endmodule
